// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder controller: FSM state encoding and
// the counter-width helper.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit counter is loaded with WIDTH-1 and counts down to 0, never wrapping.
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/bit_adder_cell.sv
// One-bit combinational full adder slice, driven once per cycle by the
// serial controller.
module bit_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add controller: one full-adder slice iterated LSB-first over WIDTH
// cycles. Define SERIAL_ADDER_SUB_EN to add the sub port (A - B via ~B + 1).
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             carry_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CW = cnt_w(WIDTH);

  state_e           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic [CW-1:0]    cnt;
  logic             cy;
  logic             s_bit, c_bit;
  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic [WIDTH-1:0] res_nxt;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtract as A + ~B + 1; carry_out=1 then means no borrow.
  assign b_load = sub ? ~op_b : op_b;
  assign c_load = sub ? 1'b1 : carry_in;
`else
  assign b_load = op_b;
  assign c_load = carry_in;
`endif

  bit_adder_cell u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (cy),
    .s    (s_bit),
    .cout (c_bit)
  );

  assign res_nxt = {s_bit, res_sr[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      cnt       <= '0;
      cy        <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr <= op_a;
            b_sr <= b_load;
            cy   <= c_load;
            cnt  <= CW'(WIDTH - 1);
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_nxt;
          cy     <= c_bit;
          // Last bit: publish the whole result; outputs hold until the next one.
          if (cnt == '0) begin
            sum       <= res_nxt;
            carry_out <= c_bit;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready = (state == IDLE);
  assign busy  = (state == RUN) || (state == DONE);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed + randomised bench for serial_adder_ctrl (WIDTH=8); covers latency,
// hold behaviour, ignored starts, mid-run reset and done spacing.
module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] op_a, op_b;
  logic             carry_in;
  logic             sub;
  logic             ready, busy, done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;

  int nvec;
  int nerr;
  int ecnt;
  int prev_done;
  bit have_prev;
  logic [WIDTH-1:0] last_sum;
  logic             last_co;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
    .carry_in  (carry_in),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) ecnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge while idle. inj pulses extra starts at edges k+3, k+8
  // and k+9 (the DONE cycle); all of them must be ignored.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic sb, input bit inj,
                        input logic [WIDTH-1:0] es, input logic ec);
    int e;
    chk("ready_pre", ready, 1);
    start = 1'b1; op_a = a; op_b = b; carry_in = cin; sub = sb;
    @(negedge clk);
    start = 1'b0; op_a = 8'hA5; op_b = 8'h5A; carry_in = 1'b1; sub = 1'b0;
    e = 0;
    chk("busy_run", {ready, busy}, 2'b01);
    while (!done && e < 40) begin
      if (inj && (e == 2 || e == 7)) begin
        start = 1'b1; op_a = 8'hEE; op_b = 8'h11;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      e++;
      if (e == 4) chk("hold", {carry_out, sum}, {last_co, last_sum});
    end
    chk("latency", e, WIDTH);
    chk("sum", sum, es);
    chk("carry_out", carry_out, ec);
    chk("busy_done", {ready, busy}, 2'b01);
    if (have_prev) chk("spacing", ecnt - prev_done, WIDTH + 2);
    prev_done = ecnt;
    have_prev = 1'b1;
    if (inj) begin
      start = 1'b1; op_a = 8'hEE; op_b = 8'h11;
    end
    @(negedge clk);
    start = 1'b0;
    chk("done_pulse", done, 0);
    chk("ready_post", {ready, busy}, 2'b10);
    if (inj) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("no_queue", {ready, busy, done}, 3'b100);
        chk("sum_kept", sum, es);
      end
      have_prev = 1'b0;
    end
    last_sum = es;
    last_co  = ec;
  endtask

  initial begin
    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] ra, rb;
    logic             rc, rs;
    int               e;

    nvec = 0; nerr = 0; ecnt = 0; prev_done = 0; have_prev = 1'b0;
    last_sum = '0; last_co = 1'b0;
    start = 1'b0; op_a = '0; op_b = '0; carry_in = 1'b0; sub = 1'b0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_flags", {ready, busy, done}, 3'b100);
    chk("rst_sum", {carry_out, sum}, 9'h000);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_flags", {ready, busy, done}, 3'b100);

    // Scenario 1
    run_op(8'h5A, 8'h33, 1'b0, 1'b0, 1'b0, 8'h8D, 1'b0);
    // Scenario 3: ignored starts, sum holds 0x8D mid-run
    run_op(8'h12, 8'h34, 1'b0, 1'b0, 1'b1, 8'h46, 1'b0);
    // Scenario 2: back-to-back at earliest legal start
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b1);

    // Scenario 4: reset mid-run
    start = 1'b1; op_a = 8'h77; op_b = 8'h88; carry_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (e = 0; e < 3; e++) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_flags", {ready, busy, done}, 3'b100);
    chk("mid_rst_sum", {carry_out, sum}, 9'h000);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 1) rst_n = 1'b1;
      chk("no_done_after_rst", done, 0);
    end
    last_sum = '0; last_co = 1'b0; have_prev = 1'b0;
    run_op(8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 8'h02, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    run_op(8'h10, 8'h01, 1'b0, 1'b1, 1'b0, 8'h0F, 1'b1);
    run_op(8'h01, 8'h02, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0);
`endif

    // Randomised ops under continuous start; spacing checked each done
    for (int n = 0; n < 1000; n++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      if (rs) r = {1'b0, ra} + {1'b0, ~rb} + 9'd1;
      else    r = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      run_op(ra, rb, rc, rs, 1'b0, r[WIDTH-1:0], r[WIDTH]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
